se_fc_mac_engine: RTL and testbench
===================================

SE_FC_MAC_ENGINE -- requirements
Module: se_fc_mac_engine

Interface
REQ-001 SHALL have parameter BITSIZE, default 14, width of weight, activation and output elements.
REQ-002 SHALL have parameter LANES, default 32, parallel output neurons per group.
REQ-003 SHALL have parameter ACC_W, default 40, signed accumulator width per lane.
REQ-004 SHALL have parameter FRAC, default 7, fractional right-shift applied before output saturation.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle job request, sampled only in IDLE.
REQ-008 SHALL have port in_len  input  10  input vector length per job; sampled with start.
REQ-009 SHALL have port out_groups  input  6  number of LANES-wide output groups; sampled with start.
REQ-010 SHALL have port base_index  input  15  first weight-row index of the job; sampled with start.
REQ-011 SHALL have port w_index / w_en / w_rd  output  15/1/1  weight-memory address, enable, read strobe.
REQ-012 SHALL have port w_data  input  BITSIZE*LANES  signed weight row, valid one cycle after w_rd.
REQ-013 SHALL have port act_addr / act_rd  output  10/1  activation-buffer address and read strobe.
REQ-014 SHALL have port act_data  input  BITSIZE  signed activation, valid one cycle after act_rd.
REQ-015 SHALL have port out_data  output  BITSIZE*LANES  saturated lane results, lane i at bits [i*BITSIZE +: BITSIZE].
REQ-016 SHALL have ports out_valid  output  1, out_ready  input  1  valid/ready result handshake.
REQ-017 SHALL have ports busy  output  1, done  output  1  job active; one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, OUT, FIN.
REQ-019 IDLE: start with in_len!=0 and out_groups!=0 SHALL latch inputs, clear accumulators, go FETCH; start with either zero SHALL pulse done next cycle, no memory access.
REQ-020 FETCH: each cycle k=0..in_len-1 SHALL assert w_en=w_rd=act_rd=1, w_index=base_index+g*in_len+k (mod 2^15), act_addr=k; after k=in_len-1 go DRAIN.
REQ-021 Each lane SHALL accumulate acc_i += w_data lane i * act_data (full 2*BITSIZE signed product, sign-extended to ACC_W) in the cycle the data is valid.
REQ-022 DRAIN SHALL last one cycle (final product accumulation), then go OUT.
REQ-023 OUT: out_valid=1, out_data_i = saturate_to_BITSIZE(acc_i >>> FRAC) (arithmetic shift, truncation toward -inf); out_data SHALL stay stable until out_ready.
REQ-024 On out_valid&&out_ready: if g<out_groups-1 SHALL increment g, clear accumulators, go FETCH next cycle; else go FIN.
REQ-025 FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-026 Latency start-to-first out_valid SHALL be in_len+2 cycles; no memory strobes outside FETCH.
REQ-027 busy SHALL be 1 in FETCH, DRAIN, OUT, FIN; start while busy SHALL be ignored.
REQ-028 w_index wrap past 32767 SHALL continue at 0 without error.

Reset
REQ-029 rst SHALL force IDLE; busy, done, out_valid, w_en, w_rd, act_rd = 0; w_index, act_addr, out_data, accumulators, g = 0, at the next clock edge, including mid-job.
REQ-030 start asserted in the cycle rst is high SHALL be ignored.

Configuration
REQ-031 With SE_FC_RELU_EN defined, negative shifted accumulator SHALL output 0 before saturation (first SE FC); without it, signed saturation only, range [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].

Structure
REQ-032 Package se_fc_pkg SHALL hold BITSIZE, LANES, ACC_W, FRAC defaults, state enumeration and the saturation function.
REQ-033 Sub-module se_fc_lane (one multiply-accumulate-saturate lane) SHALL be instantiated LANES times by generate.

Verification
REQ-034 in_len=4, out_groups=1, base_index=100, all weights 1.0 (128), acts 1.0 (128) -> w_index 100..103, out_valid at cycle 6, every lane 512 (4.0).
REQ-035 in_len=3, out_groups=2, base_index=32766 -> indices 32766,32767,0 then 1,2,3; two results, done one cycle after second accept.
REQ-036 weights 8191, acts 8191, in_len=8 -> all lanes 8191 (positive saturation); negated acts -> -8192, or 0 with SE_FC_RELU_EN.
REQ-037 out_ready low 5 cycles in OUT -> out_data stable, no w_rd, next group starts cycle after acceptance.
REQ-038 rst asserted mid-FETCH at k=2 -> next cycle all outputs 0, IDLE; new start completes correctly.
REQ-039 start with in_len=0 -> done pulse next cycle, w_rd never asserted, busy stays 0.

Source files
------------

// File: rtl/se_fc_pkg.sv
// se_fc_pkg: shared defaults, FSM state codes and the shift/saturate helper
// for the fully-connected MAC engine.
package se_fc_pkg;

   localparam int unsigned DEF_BITSIZE = 14;
   localparam int unsigned DEF_LANES   = 32;
   localparam int unsigned DEF_ACC_W   = 40;
   localparam int unsigned DEF_FRAC    = 7;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_DRAIN = 3'd2;
   localparam logic [2:0] ST_OUT   = 3'd3;
   localparam logic [2:0] ST_FIN   = 3'd4;

   // Arithmetic right shift (rounds toward -inf), optional clamp of negatives
   // to zero, then signed saturation to a 'bits'-wide result. Works on a
   // 64-bit container so any accumulator up to 64 bits can use it.
   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                   input int unsigned      frac,
                                                   input int unsigned      bits,
                                                   input logic             relu);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = v >>> frac;
      if (relu && (s < 64'sd0))
         s = '0;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bits - 1));
      if (s > hi)
         sat_shift = hi;
      else if (s < lo)
         sat_shift = lo;
      else
         sat_shift = s;
   endfunction

endpackage

// File: rtl/se_fc_mac_engine_if.sv
// se_fc_mac_engine_if: weight-memory, activation-buffer and result stream
// signals of the MAC engine. master = engine side, slave = memories/consumer.
interface se_fc_mac_engine_if
   import se_fc_pkg::*;
#(
   parameter int unsigned BITSIZE = DEF_BITSIZE,
   parameter int unsigned LANES   = DEF_LANES
);
   logic [14:0]              w_index;
   logic                     w_en;
   logic                     w_rd;
   logic [BITSIZE*LANES-1:0] w_data;
   logic [9:0]               act_addr;
   logic                     act_rd;
   logic [BITSIZE-1:0]       act_data;
   logic [BITSIZE*LANES-1:0] out_data;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output w_index, w_en, w_rd, act_addr, act_rd, out_data, out_valid,
      input  w_data, act_data, out_ready
   );

   modport slave (
      input  w_index, w_en, w_rd, act_addr, act_rd, out_data, out_valid,
      output w_data, act_data, out_ready
   );
endinterface

// File: rtl/se_fc_lane.sv
// se_fc_lane: one multiply-accumulate lane with shifted, saturated output.
// Optional feature macro: SE_FC_RELU_EN (negative results forced to zero).
module se_fc_lane
   import se_fc_pkg::*;
#(
   parameter int unsigned BITSIZE = DEF_BITSIZE,
   parameter int unsigned ACC_W   = DEF_ACC_W,
   parameter int unsigned FRAC    = DEF_FRAC
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      en,
   input  logic signed [BITSIZE-1:0] w,
   input  logic signed [BITSIZE-1:0] a,
   output logic signed [BITSIZE-1:0] y
);

`ifdef SE_FC_RELU_EN
   localparam logic RELU = 1'b1;
`else
   localparam logic RELU = 1'b0;
`endif

   logic signed [ACC_W-1:0]     acc;
   logic signed [2*BITSIZE-1:0] prod;

   assign prod = (2*BITSIZE)'(w) * (2*BITSIZE)'(a);

   // Accumulator: cleared at job/group start, adds the product when data is valid
   always_ff @(posedge clk) begin
      if (rst || clr)
         acc <= '0;
      else if (en)
         acc <= acc + {{(ACC_W-2*BITSIZE){prod[2*BITSIZE-1]}}, prod};
   end

   assign y = BITSIZE'(sat_shift(64'(acc), FRAC, BITSIZE, RELU));

endmodule

// File: rtl/se_fc_mac_engine.sv
// se_fc_mac_engine: fully-connected layer MAC engine. Streams in_len weight
// rows and activations per output group into LANES accumulators, then
// presents saturated results on a valid/ready handshake.
// Optional feature macro: SE_FC_RELU_EN (applied inside se_fc_lane).
module se_fc_mac_engine
   import se_fc_pkg::*;
#(
   parameter int unsigned BITSIZE = DEF_BITSIZE,
   parameter int unsigned LANES   = DEF_LANES,
   parameter int unsigned ACC_W   = DEF_ACC_W,
   parameter int unsigned FRAC    = DEF_FRAC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [9:0]          in_len,
   input  logic [5:0]          out_groups,
   input  logic [14:0]         base_index,
   output logic                busy,
   output logic                done,
   se_fc_mac_engine_if.master  bus
);

   logic [2:0]               state;
   logic [9:0]               len_q;
   logic [5:0]               groups_q;
   logic [5:0]               g;
   logic                     rd_d;
   logic                     acc_clr;
   logic                     acc_en;
   logic [BITSIZE*LANES-1:0] lane_out;

   assign busy          = (state != ST_IDLE);
   assign acc_en        = rd_d;
   assign bus.out_data  = lane_out;

   // Accumulator clear on job acceptance and on moving to the next group
   always_comb begin
      acc_clr = 1'b0;
      if (state == ST_IDLE && start && in_len != '0 && out_groups != '0)
         acc_clr = 1'b1;
      if (state == ST_OUT && bus.out_ready && g < groups_q - 6'd1)
         acc_clr = 1'b1;
   end

   // Control FSM; w_index simply keeps counting across groups, since the next
   // group's first row directly follows the previous group's last row.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         len_q         <= '0;
         groups_q      <= '0;
         g             <= '0;
         rd_d          <= 1'b0;
         done          <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.w_en      <= 1'b0;
         bus.w_rd      <= 1'b0;
         bus.act_rd    <= 1'b0;
         bus.w_index   <= '0;
         bus.act_addr  <= '0;
      end else begin
         done <= 1'b0;
         rd_d <= bus.w_rd;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (in_len != '0 && out_groups != '0) begin
                     len_q        <= in_len;
                     groups_q     <= out_groups;
                     g            <= '0;
                     bus.w_index  <= base_index;
                     bus.act_addr <= '0;
                     bus.w_en     <= 1'b1;
                     bus.w_rd     <= 1'b1;
                     bus.act_rd   <= 1'b1;
                     state        <= ST_FETCH;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               bus.w_index <= bus.w_index + 15'd1;
               if (bus.act_addr == len_q - 10'd1) begin
                  bus.w_en   <= 1'b0;
                  bus.w_rd   <= 1'b0;
                  bus.act_rd <= 1'b0;
                  state      <= ST_DRAIN;
               end else begin
                  bus.act_addr <= bus.act_addr + 10'd1;
               end
            end
            ST_DRAIN: begin
               bus.out_valid <= 1'b1;
               state         <= ST_OUT;
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  if (g < groups_q - 6'd1) begin
                     g            <= g + 6'd1;
                     bus.act_addr <= '0;
                     bus.w_en     <= 1'b1;
                     bus.w_rd     <= 1'b1;
                     bus.act_rd   <= 1'b1;
                     state        <= ST_FETCH;
                  end else begin
                     done  <= 1'b1;
                     state <= ST_FIN;
                  end
               end
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // One MAC lane per output neuron of the current group
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      se_fc_lane #(
         .BITSIZE (BITSIZE),
         .ACC_W   (ACC_W),
         .FRAC    (FRAC)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .clr (acc_clr),
         .en  (acc_en),
         .w   (bus.w_data[i*BITSIZE +: BITSIZE]),
         .a   (bus.act_data),
         .y   (lane_out[i*BITSIZE +: BITSIZE])
      );
   end

endmodule

// File: tb/tb_se_fc_mac_engine.sv
// tb_se_fc_mac_engine: directed self-checking bench for se_fc_mac_engine.
module tb_se_fc_mac_engine;

   localparam int BITSIZE = 14;
   localparam int LANES   = 32;
   localparam int RW      = BITSIZE * LANES;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  in_len;
   logic [5:0]  out_groups;
   logic [14:0] base_index;
   logic        busy;
   logic        done;

   int compared   = 0;
   int mismatched = 0;

   se_fc_mac_engine_if #(.BITSIZE(BITSIZE), .LANES(LANES)) bus ();

   se_fc_mac_engine #(
      .BITSIZE (BITSIZE),
      .LANES   (LANES),
      .ACC_W   (40),
      .FRAC    (7)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_len     (in_len),
      .out_groups (out_groups),
      .base_index (base_index),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // memory models: 0 = every lane w_const, 1 = lane i weight (i-16)*16
   int                 w_mode;
   logic signed [13:0] w_const;
   logic signed [13:0] a_const;

   function automatic logic [RW-1:0] row_of();
      logic [RW-1:0] r;
      for (int i = 0; i < LANES; i++)
         r[i*BITSIZE +: BITSIZE] = (w_mode == 0) ? w_const : 14'((i - 16) * 16);
      return r;
   endfunction

   always @(posedge clk) begin
      if (bus.w_rd)   bus.w_data   <= row_of();
      if (bus.act_rd) bus.act_data <= a_const;
   end

   int idx_q[$];
   int addr_q[$];
   int strobe_bad;
   always @(posedge clk) begin
      if (bus.w_rd) begin
         idx_q.push_back(int'(bus.w_index));
         addr_q.push_back(int'(bus.act_addr));
         if (!bus.w_en || !bus.act_rd) strobe_bad++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int len, input int groups, input int base);
      in_len     = 10'(len);
      out_groups = 6'(groups);
      base_index = 15'(base);
      idx_q.delete();
      addr_q.delete();
      strobe_bad = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!bus.out_valid && cyc < 300) begin
         tick();
         cyc++;
      end
      if (!bus.out_valid) begin
         compared++;
         mismatched++;
         $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 1", bus.out_valid, cyc);
      end
   endtask

   task automatic accept();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      compared++;
      if ({busy, done, bus.out_valid, bus.w_en, bus.w_rd, bus.act_rd} !== 6'b0) begin
         mismatched++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {busy, done, bus.out_valid, bus.w_en, bus.w_rd, bus.act_rd});
      end
      compared++;
      if (bus.w_index !== 15'd0 || bus.act_addr !== 10'd0 || bus.out_data !== '0) begin
         mismatched++;
         $display("FAIL reset_data: w_index=%0d act_addr=%0d out_data=%h required 0",
                  bus.w_index, bus.act_addr, bus.out_data);
      end
   endtask

   task automatic test_basic();
      int            cyc;
      logic [13:0]   v;
      logic [RW-1:0] exp;
      w_mode = 0; w_const = 14'sd128; a_const = 14'sd128;
      start_job(4, 1, 100);
      compared++;
      if (busy !== 1'b1 || bus.w_rd !== 1'b1 || bus.w_index !== 15'd100) begin
         mismatched++;
         $display("FAIL basic_first_fetch: busy=%b w_rd=%b w_index=%0d required 1 1 100",
                  busy, bus.w_rd, bus.w_index);
      end
      wait_valid(cyc);
      compared++;
      if (cyc !== 6) begin
         mismatched++;
         $display("FAIL basic_latency: got %0d required 6", cyc);
      end
      v = 14'd512;
      exp = {LANES{v}};
      compared++;
      if (bus.out_data !== exp) begin
         mismatched++;
         $display("FAIL basic_data: got %h required %h", bus.out_data, exp);
      end
      compared++;
      if (idx_q.size() != 4 || idx_q[0] != 100 || idx_q[3] != 103 || addr_q[0] != 0 ||
          addr_q[3] != 3 || strobe_bad != 0) begin
         mismatched++;
         $display("FAIL basic_indices: n=%0d first=%0d last=%0d bad=%0d required 4 100 103 0",
                  idx_q.size(), idx_q[0], idx_q[idx_q.size()-1], strobe_bad);
      end
      accept();
      compared++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         mismatched++;
         $display("FAIL basic_done: done=%b busy=%b required 1 1", done, busy);
      end
      tick();
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL basic_idle: done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic test_wrap();
      int            cyc;
      int            exp_idx[6];
      logic [13:0]   v;
      logic [RW-1:0] exp;
      bit            ok;
      exp_idx = '{32766, 32767, 0, 1, 2, 3};
      w_mode = 0; w_const = 14'sd128; a_const = 14'sd128;
      v = 14'd384;
      exp = {LANES{v}};
      start_job(3, 2, 32766);
      wait_valid(cyc);
      compared++;
      if (bus.out_data !== exp) begin
         mismatched++;
         $display("FAIL wrap_data0: got %h required %h", bus.out_data, exp);
      end
      accept();
      compared++;
      if (bus.w_rd !== 1'b1 || bus.w_index !== 15'd1 || bus.out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL wrap_next_group: w_rd=%b w_index=%0d out_valid=%b required 1 1 0",
                  bus.w_rd, bus.w_index, bus.out_valid);
      end
      wait_valid(cyc);
      compared++;
      if (bus.out_data !== exp) begin
         mismatched++;
         $display("FAIL wrap_data1: got %h required %h", bus.out_data, exp);
      end
      ok = (idx_q.size() == 6);
      for (int i = 0; i < 6 && ok; i++)
         if (idx_q[i] != exp_idx[i]) ok = 0;
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL wrap_indices: n=%0d idx0=%0d idx2=%0d required 6 32766 0",
                  idx_q.size(), idx_q[0], idx_q[2]);
      end
      accept();
      compared++;
      if (done !== 1'b1) begin
         mismatched++;
         $display("FAIL wrap_done: got %b required 1", done);
      end
      tick();
   endtask

   task automatic test_saturate();
      int            cyc;
      logic [13:0]   v;
      logic [RW-1:0] exp;
      w_mode = 0; w_const = 14'sd8191; a_const = 14'sd8191;
      start_job(8, 1, 0);
      wait_valid(cyc);
      v = 14'd8191;
      exp = {LANES{v}};
      compared++;
      if (bus.out_data !== exp) begin
         mismatched++;
         $display("FAIL sat_pos: got %h required %h", bus.out_data, exp);
      end
      accept();
      tick();
      a_const = -14'sd8191;
      start_job(8, 1, 0);
      wait_valid(cyc);
`ifdef SE_FC_RELU_EN
      v = 14'd0;
`else
      v = 14'h2000;
`endif
      exp = {LANES{v}};
      compared++;
      if (bus.out_data !== exp) begin
         mismatched++;
         $display("FAIL sat_neg: got %h required %h", bus.out_data, exp);
      end
      accept();
      tick();
   endtask

   task automatic test_lanes();
      int            cyc;
      logic [RW-1:0] exp;
      logic [13:0]   v;
      w_mode = 1; a_const = 14'sd128;
      for (int i = 0; i < LANES; i++) begin
`ifdef SE_FC_RELU_EN
         v = (i < 16) ? 14'd0 : 14'((i - 16) * 32);
`else
         v = 14'((i - 16) * 32);
`endif
         exp[i*BITSIZE +: BITSIZE] = v;
      end
      start_job(2, 1, 500);
      wait_valid(cyc);
      compared++;
      if (bus.out_data !== exp) begin
         mismatched++;
         $display("FAIL lanes_data: got %h required %h", bus.out_data, exp);
      end
      accept();
      tick();
      // -1 >>> 7 must floor to -1, not truncate to 0
      w_mode = 0; w_const = -14'sd1; a_const = 14'sd1;
`ifdef SE_FC_RELU_EN
      v = 14'd0;
`else
      v = 14'h3FFF;
`endif
      exp = {LANES{v}};
      start_job(1, 1, 7);
      wait_valid(cyc);
      compared++;
      if (bus.out_data !== exp || cyc !== 3) begin
         mismatched++;
         $display("FAIL floor_shift: got %h cyc=%0d required %h cyc=3", bus.out_data, cyc, exp);
      end
      accept();
      tick();
   endtask

   task automatic test_backpressure();
      int            cyc;
      int            bad;
      logic [RW-1:0] held;
      logic [13:0]   v;
      logic [RW-1:0] exp;
      w_mode = 0; w_const = 14'sd256; a_const = 14'sd64;
      v = 14'd256;
      exp = {LANES{v}};
      start_job(2, 2, 40);
      wait_valid(cyc);
      held = bus.out_data;
      bad = 0;
      // a start request while busy must not be taken
      start = 1'b1; in_len = 10'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.out_data !== held || bus.out_valid !== 1'b1 || bus.w_rd !== 1'b0 || done !== 1'b0)
            bad++;
      end
      start = 1'b0;
      compared++;
      if (bad != 0 || held !== exp) begin
         mismatched++;
         $display("FAIL stall_stable: bad_cycles=%0d data=%h required 0 %h", bad, held, exp);
      end
      accept();
      compared++;
      if (bus.w_rd !== 1'b1 || bus.w_index !== 15'd42) begin
         mismatched++;
         $display("FAIL stall_resume: w_rd=%b w_index=%0d required 1 42", bus.w_rd, bus.w_index);
      end
      wait_valid(cyc);
      accept();
      tick();
   endtask

   task automatic test_reset_midjob();
      int            cyc;
      logic [13:0]   v;
      logic [RW-1:0] exp;
      w_mode = 0; w_const = 14'sd128; a_const = 14'sd128;
      start_job(6, 1, 0);
      tick();
      tick();
      compared++;
      if (bus.act_addr !== 10'd2 || bus.w_rd !== 1'b1) begin
         mismatched++;
         $display("FAIL midjob_k2: act_addr=%0d w_rd=%b required 2 1", bus.act_addr, bus.w_rd);
      end
      rst = 1'b1; start = 1'b1; in_len = 10'd4; out_groups = 6'd1;
      tick();
      rst = 1'b0; start = 1'b0;
      compared++;
      if ({busy, done, bus.out_valid, bus.w_en, bus.w_rd, bus.act_rd} !== 6'b0 ||
          bus.w_index !== 15'd0 || bus.act_addr !== 10'd0 || bus.out_data !== '0) begin
         mismatched++;
         $display("FAIL midjob_reset: ctrl=%b w_index=%0d act_addr=%0d out=%h required all 0",
                  {busy, done, bus.out_valid, bus.w_en, bus.w_rd, bus.act_rd},
                  bus.w_index, bus.act_addr, bus.out_data);
      end
      tick();
      compared++;
      if (busy !== 1'b0 || bus.w_rd !== 1'b0) begin
         mismatched++;
         $display("FAIL start_in_reset: busy=%b w_rd=%b required 0 0", busy, bus.w_rd);
      end
      start_job(4, 1, 200);
      wait_valid(cyc);
      v = 14'd512;
      exp = {LANES{v}};
      compared++;
      if (bus.out_data !== exp || idx_q.size() != 4 || idx_q[0] != 200) begin
         mismatched++;
         $display("FAIL midjob_restart: got %h n=%0d first=%0d required %h 4 200",
                  bus.out_data, idx_q.size(), idx_q[0], exp);
      end
      accept();
      tick();
   endtask

   task automatic test_zero_len();
      int rd_seen;
      start_job(0, 1, 10);
      compared++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL zero_len_done: done=%b busy=%b required 1 0", done, busy);
      end
      rd_seen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (busy !== 1'b0 || done !== 1'b0) rd_seen++;
      end
      compared++;
      if (idx_q.size() != 0 || rd_seen != 0) begin
         mismatched++;
         $display("FAIL zero_len_quiet: reads=%0d bad_cycles=%0d required 0 0", idx_q.size(), rd_seen);
      end
      start_job(5, 0, 10);
      compared++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL zero_groups_done: done=%b busy=%b required 1 0", done, busy);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_len = '0; out_groups = '0; base_index = '0;
      bus.out_ready = 1'b0;
      w_mode = 0; w_const = '0; a_const = '0; strobe_bad = 0;
      test_reset();
      test_basic();
      test_wrap();
      test_saturate();
      test_lanes();
      test_backpressure();
      test_reset_midjob();
      test_zero_len();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
